seq_divider_16x8: RTL

- Sequential restoring divider: the inverse companion of the team's sequential 8x8 shift-add multiplier.
- Divides a 16-bit dividend by an 8-bit divisor and produces one quotient bit per clock.
- Uses the same start/done handshake and the same 3-bit state_out code as the multiplier, so the existing 7-segment decoder can display the divider's state.
- A multiplier product fed back through this block with one of the original operands returns the other operand with remainder 0.

---
 rtl/seq_divider_16x8.sv | 114 +++++++++++
 1 files changed

// File: rtl/seq_divider_16x8.sv
// Sequential restoring divider: DW-bit dividend by VW-bit divisor, one quotient bit per clock.
// Shares the start/done handshake and 3-bit state_out code with the 8x8 shift-add multiplier.
module seq_divider_16x8 #(
  parameter int DW = 16,
  parameter int VW = 8,
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          aclr_n,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          busy,
  output logic          done,
  output logic          div_by_zero,
  output logic [2:0]    state_out
);

  // Handshake: start is a level sampled on every rising edge. It is accepted
  // only in IDLE, DONE or ERR (never in CALC). On acceptance done/div_by_zero
  // drop; done (or div_by_zero) then stays high with stable results until the
  // next accepted start. busy is high exactly while an operation is in CALC.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CALC = 3'd1,
    S_DONE = 3'd2,
    S_ERR  = 3'd5
  } state_t;

  state_t        state;
  state_t        state_nxt;

  logic [VW:0]   rem_r;
  logic [DW-1:0] shift_r;
  logic [VW-1:0] dvs_r;
  logic [CW-1:0] cnt_r;

  logic          accept;
  logic          last_iter;
  logic [VW:0]   r_shift;
  logic [VW:0]   r_next;
  logic          qbit;

  // One restoring step: bring in the next dividend bit, subtract if it fits.
  always_comb begin
    accept    = (state != S_CALC) && start;
    last_iter = (cnt_r == CW'(DW - 1));
    r_shift   = {rem_r[VW-1:0], shift_r[DW-1]};
    qbit      = (r_shift >= {1'b0, dvs_r});
    r_next    = qbit ? (r_shift - {1'b0, dvs_r}) : r_shift;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_nxt = (divisor == '0) ? S_ERR : S_CALC;
        end
      end
      S_CALC: begin
        if (last_iter) begin
          state_nxt = S_DONE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      rem_r     <= '0;
      shift_r   <= '0;
      dvs_r     <= '0;
      cnt_r     <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else if (accept) begin
      rem_r   <= '0;
      shift_r <= dividend;
      dvs_r   <= divisor;
      cnt_r   <= '0;
      // Division by zero reports a saturated quotient and the low dividend byte.
      if (divisor == '0) begin
        quotient  <= '1;
        remainder <= dividend[VW-1:0];
      end
    end else if (state == S_CALC) begin
      rem_r   <= r_next;
      shift_r <= {shift_r[DW-2:0], qbit};
      cnt_r   <= cnt_r + 1'b1;
      if (last_iter) begin
        quotient  <= {shift_r[DW-2:0], qbit};
        remainder <= r_next[VW-1:0];
      end
    end
  end

  assign busy        = (state == S_CALC);
  assign done        = (state == S_DONE);
  assign div_by_zero = (state == S_ERR);
  assign state_out   = state;

endmodule
